cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer_pkg.sv | 34 +++
 rtl/cpu_flags.sv | 55 +++++
 rtl/cpu_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sequencer_pkg
// Shared definitions for the instruction sequencer:
//   state_t      - sequencer FSM states (IDLE, FETCH1, FETCH2, EXEC1)
//   OP_*         - instruction[15:14] operation codes
//   PC_RESET     - program counter value after reset
//   opcode()     - extracts the operation field from an instruction word
//   jump_target()- JMP destination: 14-bit target zero-extended to 16 bits
// -----------------------------------------------------------------------------
package cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH1 = 2'd1,
    ST_FETCH2 = 2'd2,
    ST_EXEC1  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_ARM  = 2'b11;

  localparam logic [15:0] PC_RESET = 16'h0000;

  function automatic logic [1:0] opcode(input logic [15:0] instr);
    return instr[15:14];
  endfunction

  function automatic logic [15:0] jump_target(input logic [15:0] instr);
    return {2'b00, instr[13:0]};
  endfunction

endpackage

// File: rtl/cpu_flags.sv
// -----------------------------------------------------------------------------
// cpu_flags
// CARRY and SKIP status flip-flops.
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   load               - 1 during the execute cycle; enables flag writes
//   carry_d, carry_en  - CARRY data / write enable (from the ALU)
//   skip_d, skip_en    - SKIP data / write enable (from the ALU)
//   skip_clear         - consumes a pending skip when the skipped word is fetched
//   carry, skip        - flag outputs
// -----------------------------------------------------------------------------
module cpu_flags (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic carry_d,
  input  logic carry_en,
  input  logic skip_d,
  input  logic skip_en,
  input  logic skip_clear,
  output logic carry,
  output logic skip
);

  logic carry_r;
  logic skip_r;

  // CARRY register: written only by the ALU during execute
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_r <= 1'b0;
    end else if (load && carry_en) begin
      carry_r <= carry_d;
    end else begin
      carry_r <= carry_r;
    end
  end

  // SKIP register: written by the ALU during execute, cleared when a skip is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_r <= 1'b0;
    end else if (load && skip_en) begin
      skip_r <= skip_d;
    end else if (skip_clear) begin
      skip_r <= 1'b0;
    end else begin
      skip_r <= skip_r;
    end
  end

  assign carry = carry_r;
  assign skip  = skip_r;

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Fetch/execute sequencer: FETCH1 presents pc to memory, FETCH2 captures the
// word into the instruction register and advances pc, EXEC1 strobes the ALU
// and applies JMP/HALT. A pending skip turns FETCH2 straight back into FETCH1.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   run                   - 1 = keep fetching and executing
//   memaddr / memdata     - instruction memory address / word (1-cycle latency)
//   instruction, exec1    - instruction register and execute strobe to the ALU
//   carryin, carryen      - CARRY data / enable from the ALU
//   skipin, skipen        - SKIP data / enable from the ALU
//   carrystatus, skipstatus - flag outputs
//   pc                    - program counter
//   halted                - set by HALT, cleared only by reset
// -----------------------------------------------------------------------------
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [15:0] memaddr,
  input  logic [15:0] memdata,
  output logic [15:0] instruction,
  output logic        exec1,
  input  logic        carryin,
  input  logic        carryen,
  input  logic        skipin,
  input  logic        skipen,
  output logic        carrystatus,
  output logic        skipstatus,
  output logic [15:0] pc,
  output logic        halted
);

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] instruction_r;
  logic        exec1_r;
  logic        halted_r;
  logic        flag_load_s;
  logic        skip_clear_s;

  assign flag_load_s  = (state_r == ST_EXEC1);
  assign skip_clear_s = (state_r == ST_FETCH2) && skipstatus;

  cpu_flags u_flags (
    .clk        (clk),
    .reset      (reset),
    .load       (flag_load_s),
    .carry_d    (carryin),
    .carry_en   (carryen),
    .skip_d     (skipin),
    .skip_en    (skipen),
    .skip_clear (skip_clear_s),
    .carry      (carrystatus),
    .skip       (skipstatus)
  );

  // Sequencer FSM with program counter, instruction register and strobes.
  // pc is rewritten with its own value in the holding states so the register
  // always has an explicit source on every edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= PC_RESET;
      instruction_r <= 16'h0000;
      exec1_r       <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          exec1_r <= 1'b0;
          pc_r    <= pc_r;
          if (run && !halted_r) begin
            state_r <= ST_FETCH1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FETCH1: begin
          exec1_r <= 1'b0;
          pc_r    <= pc_r;
          state_r <= ST_FETCH2;
        end
        ST_FETCH2: begin
          instruction_r <= memdata;
          pc_r          <= pc_r + 16'd1;
          // A pending skip discards this word: no execute cycle for it.
          if (skipstatus) begin
            exec1_r <= 1'b0;
            state_r <= ST_FETCH1;
          end else begin
            exec1_r <= 1'b1;
            state_r <= ST_EXEC1;
          end
        end
        ST_EXEC1: begin
          exec1_r <= 1'b0;
          case (opcode(instruction_r))
            OP_JMP: begin
              pc_r    <= jump_target(instruction_r);
              state_r <= run ? ST_FETCH1 : ST_IDLE;
            end
            OP_HALT: begin
              pc_r     <= pc_r;
              halted_r <= 1'b1;
              state_r  <= ST_IDLE;
            end
            OP_ARM, OP_NOP: begin
              pc_r    <= pc_r;
              state_r <= run ? ST_FETCH1 : ST_IDLE;
            end
            default: begin
              pc_r    <= pc_r;
              state_r <= ST_IDLE;
            end
          endcase
        end
        default: begin
          exec1_r <= 1'b0;
          pc_r    <= pc_r;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign memaddr     = pc_r;
  assign pc          = pc_r;
  assign instruction = instruction_r;
  assign exec1       = exec1_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
// Directed bench for cpu_sequencer. A cycle-level behavioural model tracks the
// architectural state (pc, IR, flags, halted) and where the machine is inside
// the current instruction period; a negedge process compares every output to
// it. Literal checks at hand-computed cycles pin the model itself.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] memaddr;
  logic [15:0] memdata = 16'h0000;
  logic [15:0] instruction;
  logic        exec1;
  logic        carryin = 1'b0;
  logic        carryen = 1'b0;
  logic        skipin = 1'b0;
  logic        skipen = 1'b0;
  logic        carrystatus;
  logic        skipstatus;
  logic [15:0] pc;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  logic [15:0] mem [0:65535];

  cpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .memaddr     (memaddr),
    .memdata     (memdata),
    .instruction (instruction),
    .exec1       (exec1),
    .carryin     (carryin),
    .carryen     (carryen),
    .skipin      (skipin),
    .skipen      (skipen),
    .carrystatus (carrystatus),
    .skipstatus  (skipstatus),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory: word valid one cycle after the address
  always @(posedge clk) memdata <= mem[memaddr];

  // ---------------- behavioural model ----------------
  // m_pos: 0 = not running, 1/2 = first/second cycle of a word, 3 = execute
  int          m_pos = 0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ir = 16'h0000;
  logic        m_carry = 1'b0;
  logic        m_skip = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_exec = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 0; m_pc = 16'h0000; m_ir = 16'h0000;
      m_carry = 1'b0; m_skip = 1'b0; m_halt = 1'b0; m_exec = 1'b0;
    end else begin
      m_exec = 1'b0;
      if (m_pos == 0) begin
        if (run && !m_halt) m_pos = 1;
      end else if (m_pos == 1) begin
        m_pos = 2;
      end else if (m_pos == 2) begin
        m_ir = mem[m_pc];
        m_pc = m_pc + 16'd1;
        if (m_skip) begin
          m_skip = 1'b0;
          m_pos = 1;
        end else begin
          m_pos = 3;
          m_exec = 1'b1;
        end
      end else begin
        if (carryen) m_carry = carryin;
        if (skipen) m_skip = skipin;
        if (m_ir[15:14] == 2'b10) m_pc = {2'b00, m_ir[13:0]};
        if (m_ir[15:14] == 2'b01) begin
          m_halt = 1'b1;
          m_pos = 0;
        end else begin
          m_pos = run ? 1 : 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_memaddr", memaddr, m_pc);
      check("mdl_pc", pc, m_pc);
      check("mdl_instruction", instruction, m_ir);
      check("mdl_exec1", {15'd0, exec1}, {15'd0, m_exec});
      check("mdl_carry", {15'd0, carrystatus}, {15'd0, m_carry});
      check("mdl_skip", {15'd0, skipstatus}, {15'd0, m_skip});
      check("mdl_halted", {15'd0, halted}, {15'd0, m_halt});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 16; a++) mem[a] = 16'h0000;
    mem[65535] = 16'h0000;
  endtask

  // hold reset for two edges; go_run is applied together with reset release
  task automatic do_reset(input logic go_run);
    reset = 1'b1; run = 1'b0;
    carryen = 1'b0; carryin = 1'b0; skipen = 1'b0; skipin = 1'b0;
    cyc(2);
    reset = 1'b0; run = go_run;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    cyc(1);
    cmp_en = 1'b1;

    // reset state
    do_reset(1'b0);
    check("rst_pc", pc, 16'h0000);
    check("rst_instruction", instruction, 16'h0000);
    check("rst_flags", {14'd0, carrystatus, skipstatus}, 16'h0000);
    check("rst_exec1_halted", {14'd0, exec1, halted}, 16'h0000);

    // two ALU ops: exec1 on cycles 3 and 6
    clear_mem(); mem[0] = 16'hC000; mem[1] = 16'hC000;
    do_reset(1'b1);
    cyc(2); check("arm_c2_exec1", {15'd0, exec1}, 16'h0000);
    cyc(1); check("arm_c3_exec1", {15'd0, exec1}, 16'h0001);
            check("arm_c3_pc", pc, 16'h0001);
    cyc(3); check("arm_c6_exec1", {15'd0, exec1}, 16'h0001);
            check("arm_c6_pc", pc, 16'h0002);
    run = 1'b0;
    cyc(3); check("arm_idle_pc", pc, 16'h0002);

    // JMP 0005
    clear_mem(); mem[0] = 16'h8005;
    do_reset(1'b1);
    cyc(3); check("jmp_c3_instruction", instruction, 16'h8005);
    cyc(1); check("jmp_pc", pc, 16'h0005);
            check("jmp_memaddr", memaddr, 16'h0005);
    run = 1'b0;
    cyc(5);

    // skip raised during execute of word 2: word 3 fetched without exec1
    clear_mem();
    for (int a = 0; a < 5; a++) mem[a] = 16'hC000;
    mem[3] = 16'hC003;
    do_reset(1'b1);
    cyc(9); check("skip_c9_exec1", {15'd0, exec1}, 16'h0001);
            check("skip_c9_pc", pc, 16'h0003);
    skipen = 1'b1; skipin = 1'b1;
    cyc(1); skipen = 1'b0; skipin = 1'b0;
            check("skip_set", {15'd0, skipstatus}, 16'h0001);
            check("skip_c10_exec1", {15'd0, exec1}, 16'h0000);
    cyc(1); check("skip_c11_exec1", {15'd0, exec1}, 16'h0000);
    cyc(1); check("skip_cleared", {15'd0, skipstatus}, 16'h0000);
            check("skip_c12_pc", pc, 16'h0004);
            check("skip_c12_instruction", instruction, 16'hC003);
            check("skip_c12_exec1", {15'd0, exec1}, 16'h0000);
    cyc(1); check("skip_c13_exec1", {15'd0, exec1}, 16'h0000);
    cyc(1); check("skip_c14_exec1", {15'd0, exec1}, 16'h0001);
            check("skip_c14_pc", pc, 16'h0005);
    run = 1'b0;
    cyc(3);

    // carry written once, then held while carryen=0
    clear_mem();
    for (int a = 0; a < 16; a++) mem[a] = 16'hC000;
    do_reset(1'b1);
    cyc(3); carryen = 1'b1; carryin = 1'b1;
    cyc(1); carryen = 1'b0; carryin = 1'b0;
            check("carry_set", {15'd0, carrystatus}, 16'h0001);
    cyc(2); check("carry_c6_exec1", {15'd0, exec1}, 16'h0001);
    cyc(1); check("carry_held", {15'd0, carrystatus}, 16'h0001);
    cyc(3); check("carry_still", {15'd0, carrystatus}, 16'h0001);
    run = 1'b0;
    cyc(3);

    // HALT at address 2
    clear_mem(); mem[0] = 16'hC000; mem[1] = 16'hC000; mem[2] = 16'h4000;
    do_reset(1'b1);
    cyc(9); check("halt_c9_instruction", instruction, 16'h4000);
    cyc(1); check("halt_halted", {15'd0, halted}, 16'h0001);
            check("halt_pc", pc, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      cyc(1); check("halt_no_exec1", {15'd0, exec1}, 16'h0000);
    end
    check("halt_pc_frozen", pc, 16'h0003);
    reset = 1'b1;
    cyc(1); check("halt_rst_halted", {15'd0, halted}, 16'h0000);
            check("halt_rst_pc", pc, 16'h0000);

    // pc wrap FFFF -> 0000 with run dropped in FETCH1
    clear_mem();
    do_reset(1'b0);
    cyc(1);
    force dut.pc_r = 16'hFFFF;
    m_pc = 16'hFFFF;
    cyc(2);
    release dut.pc_r;
    cyc(1); check("wrap_start_pc", pc, 16'hFFFF);
    run = 1'b1;
    cyc(1); run = 1'b0;
            check("wrap_f1_memaddr", memaddr, 16'hFFFF);
    cyc(2); check("wrap_exec1", {15'd0, exec1}, 16'h0001);
            check("wrap_pc", pc, 16'h0000);
    cyc(1); check("wrap_after_exec1", {15'd0, exec1}, 16'h0000);
    cyc(3); check("wrap_idle_pc", pc, 16'h0000);
            check("wrap_idle_exec1", {15'd0, exec1}, 16'h0000);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
